// File: rtl/canvas_pkg.sv
// Shared canvas geometry, marked-pixel colours and clear-sequencer state type.
package canvas_pkg;

  localparam int unsigned CANVAS_W      = 320;
  localparam int unsigned CANVAS_H      = 240;
  localparam int unsigned CANVAS_DEPTH  = CANVAS_W * CANVAS_H;
  localparam int unsigned CANVAS_ADDR_W = 17;

  // Address compare emits for pixels outside the visible frame
  localparam logic [CANVAS_ADDR_W-1:0] OFF_FRAME_ADDR = 17'h12C01;

  // Marked-pixel colours; bits [7:6]=11 flag a marked pixel
  localparam logic [7:0] YELLOW = 8'hC0;
  localparam logic [7:0] PINK   = 8'hC1;
  localparam logic [7:0] GREEN  = 8'hC2;
  localparam logic [7:0] RED    = 8'hC3;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CLEARING,
    DONE
  } clear_state_t;

endpackage

// File: rtl/canvas_clear_sweep.sv
// Address generator for a full-canvas clear: walks 0..DEPTH-1 once per start pulse.
module canvas_clear_sweep #(
  parameter int unsigned       ADDR_W      = 17,
  parameter int unsigned       PIX_W       = 8,
  parameter int unsigned       DEPTH       = 76800,
  parameter logic [PIX_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [PIX_W-1:0]  data_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              busy;
  logic [ADDR_W-1:0] cnt;

  // Counter stops and returns to zero after the last address, so it never wraps past DEPTH-1
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start_in) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Current sweep write request
  always_comb begin
    busy_out = busy;
    we_out   = busy;
    done_out = busy && (cnt == LAST);
    addr_out = cnt;
    data_out = CLEAR_VALUE;
  end

endmodule

// File: rtl/canvas_write_arbiter.sv
// Port-B owner of the canvas BRAM: forwards compare write-back, or sweeps a clear.
module canvas_write_arbiter
  import canvas_pkg::*;
#(
  parameter int unsigned      H_PIXELS    = CANVAS_W,
  parameter int unsigned      V_PIXELS    = CANVAS_H,
  parameter int unsigned      ADDR_W      = CANVAS_ADDR_W,
  parameter int unsigned      PIX_W       = 8,
  parameter logic [PIX_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_req_in,
  input  logic              frame_start_in,
  input  logic              cmp_wr_valid_in,
  input  logic [ADDR_W-1:0] cmp_wr_addr_in,
  input  logic [PIX_W-1:0]  cmp_wr_data_in,
  output logic              bram_we_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [PIX_W-1:0]  bram_din_out,
  output logic              cmp_enable_out,
  output logic              clear_busy_out,
  output logic              clear_done_out,
  output logic [15:0]       dropped_cnt_out
);

  localparam int unsigned       DEPTH   = H_PIXELS * V_PIXELS;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  clear_state_t      state, state_n;
  logic              sw_start, sw_busy, sw_done, sw_we;
  logic [ADDR_W-1:0] sw_addr, addr_n;
  logic [PIX_W-1:0]  sw_data, din_n;
  logic              we_n, busy_n, cmp_en_n, done_n, drop_hit;

  canvas_clear_sweep #(
    .ADDR_W      (ADDR_W),
    .PIX_W       (PIX_W),
    .DEPTH       (DEPTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_sweep (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (sw_start),
    .busy_out (sw_busy),
    .done_out (sw_done),
    .we_out   (sw_we),
    .addr_out (sw_addr),
    .data_out (sw_data)
  );

  // Next state, next port-B drive and status; every output is the registered view of the current state
  always_comb begin
    state_n  = state;
    sw_start = 1'b0;
    we_n     = 1'b0;
    addr_n   = bram_addr_out;
    din_n    = bram_din_out;
    drop_hit = 1'b0;
    unique case (state)
      IDLE, ARMED: begin
        if (cmp_wr_valid_in) begin
          if (cmp_wr_addr_in < DEPTH_A) begin
            we_n   = 1'b1;
            addr_n = cmp_wr_addr_in;
            din_n  = cmp_wr_data_in;
          end else begin
            drop_hit = 1'b1;
          end
        end
        if (state == IDLE) begin
          if (clear_req_in) state_n = ARMED;
        end else if (frame_start_in) begin
          state_n  = CLEARING;
          sw_start = 1'b1;
        end
      end
      CLEARING: begin
        we_n     = sw_we;
        addr_n   = sw_addr;
        din_n    = sw_data;
        drop_hit = cmp_wr_valid_in;
        if (sw_done || !sw_busy) state_n = DONE;
      end
      DONE: begin
        drop_hit = cmp_wr_valid_in;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n   = (state == ARMED) || (state == CLEARING) || ((state == IDLE) && clear_req_in);
    cmp_en_n = (state != CLEARING) && (state != DONE);
    done_n   = (state == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      bram_we_out    <= 1'b0;
      bram_addr_out  <= '0;
      bram_din_out   <= '0;
      cmp_enable_out <= 1'b1;
      clear_busy_out <= 1'b0;
      clear_done_out <= 1'b0;
    end else begin
      state          <= state_n;
      bram_we_out    <= we_n;
      bram_addr_out  <= addr_n;
      bram_din_out   <= din_n;
      cmp_enable_out <= cmp_en_n;
      clear_busy_out <= busy_n;
      clear_done_out <= done_n;
    end
  end

  // Saturating count of discarded compare writes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dropped_cnt_out <= '0;
    end else if (drop_hit && (dropped_cnt_out != '1)) begin
      dropped_cnt_out <= dropped_cnt_out + 16'd1;
    end
  end

endmodule
